// File: rtl/pipe_mux_nx1_if.sv
// pipe_mux_nx1_if
//   Bundle of producer-side and consumer-side signals for pipe_mux_nx1.
//   master : the environment (drives data, valids, select, mode, out_ready)
//   slave  : the multiplexer (drives in_ready and the registered output)
//
//   in        N*W  packed input words, channel k at in[k*W +: W]
//   in_valid  N    per-channel data valid
//   in_ready  N    per-channel accept strobe (combinational)
//   s         SW   fixed-mode channel select
//   mode      1    0 = fixed select, 1 = round-robin scan
//   out       W    registered selected word
//   out_sel   SW   channel index of the word held in out
//   out_valid 1    out/out_sel hold an unconsumed word
//   out_ready 1    consumer accepts out this cycle
interface pipe_mux_nx1_if #(
    parameter int W  = 32,
    parameter int N  = 32,
    parameter int SW = 5
);
    logic [N*W-1:0] in;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  s;
    logic           mode;
    logic [W-1:0]   out;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in, in_valid, s, mode, out_ready,
        input  in_ready, out, out_sel, out_valid
    );

    modport slave (
        input  in, in_valid, s, mode, out_ready,
        output in_ready, out, out_sel, out_valid
    );
endinterface

// File: rtl/pipe_mux_nx1.sv
// pipe_mux_nx1
//   Registered N-to-1 word multiplexer with valid/ready flow control.
//   A single output register holds the selected word; it reloads whenever it
//   is empty or being consumed, giving one word per clock at one cycle of
//   latency. Channel choice is either the fixed select s, or (optional) a
//   round-robin scan starting at pointer P.
//
//   Build option: define PIPE_MUX_RR_EN to include round-robin mode and the
//   pointer. Without it, mode is ignored and the block is fixed-select only.
//
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    slave modport of pipe_mux_nx1_if (data, handshakes, select, output)
module pipe_mux_nx1 #(
    parameter int W  = 32,
    parameter int N  = 32,
    parameter int SW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_mux_nx1_if.slave  bus
);

    localparam logic [SW:0] N_LIM = (SW+1)'(N);

    logic [W-1:0]  out_p1;
    logic [SW-1:0] sel_p1;
    logic          vld_p1;

    logic          load_ok;
    logic          cand_ok;
    logic [SW-1:0] cand;
    logic [N-1:0]  ready;
    logic          xfer;
    logic [W-1:0]  sel_data;

`ifdef PIPE_MUX_RR_EN
    logic [SW-1:0] ptr_p1;

    // First valid channel scanning p, p+1, ..., N-1, 0, ..., p-1.
    // Returns {found, index}. Scanning backwards lets the nearest hit win.
    function automatic logic [SW:0] rr_pick(input logic [N-1:0] v,
                                            input logic [SW-1:0] p);
        logic [SW:0] r;
        int          j;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(p) + i;
            if (j >= N) j = j - N;
            if (v[j]) r = {1'b1, SW'(j)};
        end
        return r;
    endfunction
`endif

    assign load_ok = !vld_p1 || bus.out_ready;

    always_comb begin
        cand    = bus.s;
        cand_ok = ({1'b0, bus.s} < N_LIM);
`ifdef PIPE_MUX_RR_EN
        if (bus.mode) begin
            {cand_ok, cand} = rr_pick(bus.in_valid, ptr_p1);
        end
`endif
    end

    always_comb begin
        ready    = '0;
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (cand == SW'(k)) begin
                ready[k] = load_ok && cand_ok;
                sel_data = bus.in[k*W +: W];
            end
        end
    end

    assign xfer         = |(ready & bus.in_valid);
    assign bus.in_ready = ready;

    // ---- stage p1: output register (and round-robin pointer) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= '0;
            sel_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (xfer) begin
            out_p1 <= sel_data;
            sel_p1 <= cand;
            vld_p1 <= 1'b1;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

`ifdef PIPE_MUX_RR_EN
    // Pointer only moves on a round-robin grant, so it is kept across
    // fixed-mode periods and frozen during a stall (no transfer then).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_p1 <= '0;
        end else if (xfer && bus.mode) begin
            ptr_p1 <= (cand == SW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode;
`endif

    assign bus.out       = out_p1;
    assign bus.out_sel   = sel_p1;
    assign bus.out_valid = vld_p1;

endmodule
